control_divisor: RTL
====================

# control_divisor

Speed controller for the 8-bit counter's clock-divider selector. It turns three raw push-button inputs into a saturating speed selection (0 = clk, 1 = clk/2 … 4 = clk/16) and a run/pause state. It generates the clk/2–clk/16 taps from one free-running prescaler and emits a single-cycle count-enable tick at the selected rate. Sits between the board buttons and the divider mux / counter. Speed changes are applied only at the prescaler wrap point, so the selected rate never glitches.

## Interface
- SEL_MAX, 4, highest legal selection code (clk/16)
- ANCHO_PRE, 4, prescaler width; must be ≥ SEL_MAX
- iClk  in  1  single system clock, rising edge
- iReset  in  1  reset, asynchronous, active-low (0 = reset)
- iBtnMas  in  1  raw level, asynchronous; rising edge = one step slower (sel+1)
- iBtnMenos  in  1  raw level, asynchronous; rising edge = one step faster (sel−1)
- iBtnPausa  in  1  raw level, asynchronous; rising edge = toggle run/pause
- ovSel  out  3  applied selection, drives divider-mux select
- ovSelPend  out  3  requested selection not yet applied
- oClk2, oClk4, oClk8, oClk16  out  1 each  prescaler bits [0]..[3]
- oTick  out  1  one-cycle enable at the selected rate, only while running
- oCorriendo  out  1  1 = CORRE state

## Operation
- Each button: 2-flop synchronizer, then edge register; pulse = sync2 & ~prev.
- Pending select rvPend: Mas pulse → min(rvPend+1, SEL_MAX); Menos pulse → max(rvPend−1, 0); both in same cycle → unchanged.
- FSM, 2 states, registered, reset to PAUSA:
  - PAUSA: rvPre held at 0; oTick = 0; ovSel <= rvPend every cycle. Pausa pulse → CORRE.
  - CORRE: rvPre increments mod 2^ANCHO_PRE every cycle; ovSel <= rvPend only in the cycle where rvPre = all ones (wrap). Pausa pulse → PAUSA. rvPre is cleared on the transition into PAUSA.
- oTick (combinational from registers) = CORRE & (rvPre[ovSel−1:0] all ones); for ovSel = 0, oTick = 1 every CORRE cycle.
- Selections in the range 5..7 are unreachable. Any such value is treated as SEL_MAX.
- Pausa pulse and Mas/Menos pulse in the same cycle: both take effect.

## Timing
- Reset values: ovSel = 0, ovSelPend = 0, rvPre = 0, all oClkN = 0, oTick = 0, oCorriendo = 0, synchronizer/edge flops = 0.
- Reset is asserted asynchronously and released synchronously by the board. Reset mid-run clears everything immediately and returns the FSM to PAUSA.
- Button latency: an input rising before edge n produces an internal pulse that updates rvPend/FSM at edge n+2. The change is visible on ovSelPend / oCorriendo after that edge.
- Apply latency in CORRE: 1 to 2^ANCHO_PRE cycles after rvPend changes (next wrap). In PAUSA: 1 cycle.
- Tick period = 2^ovSel cycles. After entering CORRE (rvPre = 0), the first tick occurs 2^ovSel − 1 cycles later (at rvPre = 2^ovSel − 1). For ovSel = 0, the first tick is in the first CORRE cycle.
- A button held high produces exactly one pulse. Release produces none.

## Structure
- Package pkg_control_divisor: state encoding (PAUSA = 1'b0, CORRE = 1'b1), SEL_MAX, ANCHO_PRE, selection-code constants SEL_CLK..SEL_CLK16.
- Sub-module sincroniza_flanco (2-flop sync + rising-edge pulse, async active-low reset), instanced three times.
- Top contains: pending/apply select registers, prescaler, FSM, tick decode.

## Test plan
- Reset, then 3 Mas presses in PAUSA → ovSelPend = 3 and ovSel = 3, each update one cycle apart. Fourth and fifth presses → saturates at 4. Two further presses → still 4.
- From sel 0, Menos pressed 2 times → stays 0. Mas and Menos asserted in the same cycle → ovSelPend unchanged.
- Pausa pressed with ovSel = 2 → oCorriendo = 1, oTick at rvPre = 3, 7, 11, 15 (period 4). Pausa again → oTick = 0, rvPre = 0.
- Running at sel 1, Mas press at rvPre = 5 → ovSelPend = 2 immediately, ovSel stays 1 until the rvPre = 15 cycle, then 2. No tick period shorter than 2 occurs.
- Hold iBtnMas high for 50 cycles → exactly one increment.
- iReset driven low mid-run at sel 4 → all outputs 0 within the same cycle (asynchronous). After release, FSM is in PAUSA.

Source files
------------

// File: rtl/pkg_control_divisor.sv
// Shared constants and types for the speed controller.
//   SEL_MAX   : highest legal selection code (clk/16)
//   ANCHO_PRE : prescaler width, must be >= SEL_MAX
//   estado_e  : run/pause state encoding
//   sel_sat   : folds unreachable codes 5..7 onto SEL_MAX
package pkg_control_divisor;

  localparam int unsigned SEL_MAX   = 4;
  localparam int unsigned ANCHO_PRE = 4;
  localparam int unsigned ANCHO_SEL = 3;

  typedef enum logic {
    PAUSA = 1'b0,
    CORRE = 1'b1
  } estado_e;

  localparam logic [ANCHO_SEL-1:0] SEL_CLK   = 3'd0;
  localparam logic [ANCHO_SEL-1:0] SEL_CLK2  = 3'd1;
  localparam logic [ANCHO_SEL-1:0] SEL_CLK4  = 3'd2;
  localparam logic [ANCHO_SEL-1:0] SEL_CLK8  = 3'd3;
  localparam logic [ANCHO_SEL-1:0] SEL_CLK16 = 3'd4;

  localparam logic [ANCHO_SEL-1:0] SEL_TOPE = ANCHO_SEL'(SEL_MAX);

  function automatic logic [ANCHO_SEL-1:0] sel_sat(input logic [ANCHO_SEL-1:0] sel);
    return (sel > SEL_TOPE) ? SEL_TOPE : sel;
  endfunction

endpackage

// File: rtl/sincroniza_flanco.sv
// Two-flop synchronizer followed by a rising-edge detector.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   btn   : raw asynchronous button level
//   pulso : one-cycle pulse on each synchronized rising edge
module sincroniza_flanco (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulso
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign pulso = sync2_q & ~prev_q;

endmodule

// File: rtl/control_divisor.sv
// Speed controller for the counter's clock-divider selector.
//   iClk        : system clock
//   iReset      : asynchronous active-low reset
//   iBtnMas     : raw button, rising edge = one step slower
//   iBtnMenos   : raw button, rising edge = one step faster
//   iBtnPausa   : raw button, rising edge = toggle run/pause
//   ovSel       : applied selection (divider-mux select)
//   ovSelPend   : requested selection, applied at the next wrap while running
//   oClk2..16   : prescaler bits [0]..[3]
//   oTick       : one-cycle count enable at the applied rate, only while running
//   oCorriendo  : high in the running state
module control_divisor
  import pkg_control_divisor::*;
(
  input  logic                 iClk,
  input  logic                 iReset,
  input  logic                 iBtnMas,
  input  logic                 iBtnMenos,
  input  logic                 iBtnPausa,
  output logic [ANCHO_SEL-1:0] ovSel,
  output logic [ANCHO_SEL-1:0] ovSelPend,
  output logic                 oClk2,
  output logic                 oClk4,
  output logic                 oClk8,
  output logic                 oClk16,
  output logic                 oTick,
  output logic                 oCorriendo
);

  localparam logic [ANCHO_PRE-1:0] PreUno = ANCHO_PRE'(1);

  logic pulso_mas;
  logic pulso_menos;
  logic pulso_pausa;

  sincroniza_flanco u_sinc_mas (
    .clk   (iClk),
    .rst_n (iReset),
    .btn   (iBtnMas),
    .pulso (pulso_mas)
  );

  sincroniza_flanco u_sinc_menos (
    .clk   (iClk),
    .rst_n (iReset),
    .btn   (iBtnMenos),
    .pulso (pulso_menos)
  );

  sincroniza_flanco u_sinc_pausa (
    .clk   (iClk),
    .rst_n (iReset),
    .btn   (iBtnPausa),
    .pulso (pulso_pausa)
  );

  // Pending selection: saturating up/down, simultaneous presses cancel.
  logic [ANCHO_SEL-1:0] pend_q;
  logic [ANCHO_SEL-1:0] pend_d;
  logic [ANCHO_SEL-1:0] pend_sat;

  assign pend_sat = sel_sat(pend_q);

  always_comb begin
    pend_d = pend_sat;
    if (pulso_mas && !pulso_menos) begin
      if (pend_sat != SEL_TOPE) begin
        pend_d = pend_sat + 3'd1;
      end
    end else if (pulso_menos && !pulso_mas) begin
      if (pend_sat != SEL_CLK) begin
        pend_d = pend_sat - 3'd1;
      end
    end
  end

  always_ff @(posedge iClk or negedge iReset) begin
    if (!iReset) begin
      pend_q <= SEL_CLK;
    end else begin
      pend_q <= pend_d;
    end
  end

  // Run/pause FSM with the prescaler and applied selection as registered outputs.
  estado_e              estado_q;
  logic [ANCHO_PRE-1:0] pre_q;
  logic [ANCHO_SEL-1:0] sel_q;

  always_ff @(posedge iClk or negedge iReset) begin
    if (!iReset) begin
      estado_q <= PAUSA;
      pre_q    <= '0;
      sel_q    <= SEL_CLK;
    end else begin
      unique case (estado_q)
        PAUSA: begin
          pre_q <= '0;
          sel_q <= pend_q;
          if (pulso_pausa) begin
            estado_q <= CORRE;
          end
        end
        CORRE: begin
          // Only swap rates at the wrap so the tick spacing never glitches.
          if (pre_q == '1) begin
            sel_q <= pend_q;
          end
          if (pulso_pausa) begin
            estado_q <= PAUSA;
            pre_q    <= '0;
          end else begin
            pre_q <= pre_q + PreUno;
          end
        end
      endcase
    end
  end

  // Tick when the low ovSel prescaler bits are all ones; empty mask for sel 0.
  logic [ANCHO_SEL-1:0] sel_ef;
  logic [ANCHO_PRE-1:0] mascara;

  assign sel_ef = sel_sat(sel_q);

  always_comb begin
    mascara = '0;
    for (int i = 0; i < ANCHO_PRE; i++) begin
      mascara[i] = (i < int'(sel_ef));
    end
  end

  assign oTick      = (estado_q == CORRE) && ((pre_q & mascara) == mascara);
  assign oCorriendo = (estado_q == CORRE);
  assign ovSel      = sel_q;
  assign ovSelPend  = pend_q;
  assign oClk2      = pre_q[0];
  assign oClk4      = pre_q[1];
  assign oClk8      = pre_q[2];
  assign oClk16     = pre_q[3];

endmodule
